// File: rtl/gshare_branch_predictor_pkg.sv
// gshare_branch_predictor_pkg: shared widths, sweep states, bus widths and counter helper for the gshare predictor
package gshare_branch_predictor_pkg;
  localparam int PTINDEXBITS = 8;
  localparam int BTBINDEXBITS = 4;
  localparam int ADDRBITS = 32;
  localparam int TAGBITS = ADDRBITS - BTBINDEXBITS - 2;
  localparam int PTENTRYBITS = 2;
  localparam logic [PTENTRYBITS-1:0] PT_WEAK_NT = PTENTRYBITS'(1);
  // FE->DE->AGEX carries {pred_taken, pred_target, pt_index}; AGEX->FE carries {mispredict, redirect_pc}
  localparam int LOOKUP_BUS_W = 1 + ADDRBITS + PTINDEXBITS;
  localparam int UPDATE_BUS_W = 1 + ADDRBITS;
  typedef enum logic {INIT = 1'b0, RUN = 1'b1} bp_state_e;
  function automatic logic [PTENTRYBITS-1:0] pt_next(input logic [PTENTRYBITS-1:0] c, input logic up);
    return up ? ((c == '1) ? c : c + PTENTRYBITS'(1)) : ((c == '0) ? c : c - PTENTRYBITS'(1));
  endfunction
endpackage

// File: rtl/gshare_branch_predictor_btb.sv
// bp_btb: direct-mapped branch target buffer, one combinational read port and one write/invalidate port
module bp_btb
  import gshare_branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BTBINDEXBITS,
  parameter int DBITS = ADDRBITS
) (
  input  logic             clk,
  input  logic [DBITS-1:0] rd_pc,
  output logic             rd_hit,
  output logic [DBITS-1:0] rd_target,
  input  logic             wr_en,
  input  logic             wr_valid,
  input  logic [DBITS-1:0] wr_pc,
  input  logic [DBITS-1:0] wr_target
);
  localparam int DEPTH = 2 ** INDEX_BITS;
  localparam int TAG_BITS = DBITS - INDEX_BITS - 2;
  logic                valid [DEPTH];
  logic [TAG_BITS-1:0] tag [DEPTH];
  logic [DBITS-1:0]    target [DEPTH];
  logic [INDEX_BITS-1:0] rd_index, wr_index;
  logic unused_pc_bits;
  assign rd_index = rd_pc[INDEX_BITS+1:2];
  assign wr_index = wr_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};
  assign rd_hit = valid[rd_index] && tag[rd_index] == rd_pc[DBITS-1:INDEX_BITS+2];
  assign rd_target = target[rd_index];
  always_ff @(posedge clk)
    if (wr_en) begin
      valid[wr_index] <= wr_valid;
      tag[wr_index] <= wr_pc[DBITS-1:INDEX_BITS+2];
      target[wr_index] <= wr_target;
    end
endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: gshare direction predictor + BTB with init sweep and registered redirect.
// Define GSHARE_BP_STATS_EN to build the saturating branch/mispredict statistics counters.
module gshare_branch_predictor
  import gshare_branch_predictor_pkg::*;
#(
  parameter int PT_INDEX_BITS = PTINDEXBITS,
  parameter int BTB_INDEX_BITS = BTBINDEXBITS,
  parameter int DBITS = ADDRBITS
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     bp_ready,
  input  logic [DBITS-1:0]         lookup_pc,
  output logic                     pred_taken,
  output logic [DBITS-1:0]         pred_target,
  output logic                     btb_hit,
  output logic [PT_INDEX_BITS-1:0] pt_index,
  input  logic                     upd_valid,
  input  logic [DBITS-1:0]         upd_pc,
  input  logic                     upd_is_branch,
  input  logic                     upd_is_cond,
  input  logic                     upd_taken,
  input  logic [DBITS-1:0]         upd_target,
  input  logic [PT_INDEX_BITS-1:0] upd_pt_index,
  input  logic                     upd_pred_taken,
  input  logic [DBITS-1:0]         upd_pred_target,
  output logic                     mispredict,
  output logic [DBITS-1:0]         redirect_pc,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispredicts
);
  localparam int PT_DEPTH = 2 ** PT_INDEX_BITS;
  bp_state_e state;
  logic [PT_INDEX_BITS-1:0] idx, bhr;
  logic [PTENTRYBITS-1:0] pt [PT_DEPTH];
  logic raw_hit, accept, sweep_btb, btb_we, btb_wv;
  logic [DBITS-1:0] seq_pc, actual_npc, pred_npc, btb_wpc;
  assign bp_ready = state == RUN;
  assign pt_index = lookup_pc[PT_INDEX_BITS+1:2] ^ bhr;
  assign btb_hit = raw_hit & bp_ready;
  assign pred_taken = btb_hit & pt[pt_index][PTENTRYBITS-1];
  assign accept = upd_valid & bp_ready;
  assign seq_pc = upd_pc + DBITS'(4);
  assign actual_npc = upd_taken ? upd_target : seq_pc;
  assign pred_npc = upd_pred_taken ? upd_pred_target : seq_pc;
  // only the first BTB-depth sweep indices map onto BTB entries
  assign sweep_btb = state == INIT && (idx >> BTB_INDEX_BITS) == '0;
  assign btb_we = ~reset & (sweep_btb | (accept & (upd_is_branch ? upd_taken : upd_pred_taken)));
  assign btb_wv = accept & upd_is_branch;
  assign btb_wpc = (state == INIT) ? DBITS'({idx, 2'b00}) : upd_pc;
  bp_btb #(.INDEX_BITS(BTB_INDEX_BITS), .DBITS(DBITS)) u_btb (
    .clk(clk),
    .rd_pc(lookup_pc),
    .rd_hit(raw_hit),
    .rd_target(pred_target),
    .wr_en(btb_we),
    .wr_valid(btb_wv),
    .wr_pc(btb_wpc),
    .wr_target(upd_target)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= INIT;
      idx <= '0;
      bhr <= '0;
      mispredict <= 1'b0;
      redirect_pc <= '0;
    end else if (state == INIT) begin
      idx <= idx + PT_INDEX_BITS'(1);
      bhr <= '0;
      mispredict <= 1'b0;
      if (idx == '1) state <= RUN;
    end else begin
      mispredict <= upd_valid && actual_npc != pred_npc;
      if (upd_valid) redirect_pc <= actual_npc;
      if (upd_valid && upd_is_branch && upd_is_cond) bhr <= {bhr[PT_INDEX_BITS-2:0], upd_taken};
    end
  always_ff @(posedge clk)
    if (!reset && state == INIT) pt[idx] <= PT_WEAK_NT;
    else if (!reset && accept && upd_is_branch) pt[upd_pt_index] <= pt_next(pt[upd_pt_index], upd_taken);
`ifdef GSHARE_BP_STATS_EN
  always_ff @(posedge clk)
    if (reset) begin
      stat_branches <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (accept && upd_is_branch && stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (mispredict && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
`else
  assign stat_branches = '0;
  assign stat_mispredicts = '0;
`endif
endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Gshare direction predictor plus direct-mapped branch target buffer serving the fetch stage. It sits between FE and AGEX. FE looks it up every cycle. AGEX sends each resolved control-flow instruction back to it, and it answers with a registered mispredict/redirect and trains its tables. After reset it clears its tables with a sweep FSM, and holds FE off until the sweep is done.

## Interface
Parameters:
- PT_INDEX_BITS, 8, pattern-table index width; BHR width is the same; PT depth 2^PT_INDEX_BITS
- BTB_INDEX_BITS, 4, BTB index width; BTB depth 2^BTB_INDEX_BITS; must be ≤ PT_INDEX_BITS
- DBITS, 32, address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- bp_ready  out  1  high once init sweep is complete; FE must not fetch while low
- lookup_pc  in  DBITS  PC being fetched
- pred_taken  out  1  predicted taken
- pred_target  out  DBITS  predicted target, valid when btb_hit
- btb_hit  out  1  BTB valid and tag match
- pt_index  out  PT_INDEX_BITS  gshare index used; carried down the pipeline
- upd_valid  in  1  AGEX resolving a control-flow or mispredicted instruction this cycle
- upd_pc  in  DBITS  PC of resolved instruction
- upd_is_branch  in  1  conditional branch, JAL or JALR
- upd_is_cond  in  1  conditional branch; BHR shifts only for these
- upd_taken  in  1  actual direction (br_cond)
- upd_target  in  DBITS  actual target (newpc)
- upd_pt_index  in  PT_INDEX_BITS  carried pt_index
- upd_pred_taken  in  1  carried pred_taken
- upd_pred_target  in  DBITS  carried pred_target
- mispredict  out  1  one-cycle redirect pulse
- redirect_pc  out  DBITS  correct next PC, valid with mispredict
- stat_branches, stat_mispredicts  out  32 each  statistics; see Configuration

## Operation
- Sweep FSM has two states, INIT and RUN.
  - Reset loads INIT with index 0.
  - In INIT, each cycle writes PT[i]=2'b01 and clears the BHR. When i < BTB depth it also clears BTB valid[i].
  - After i = 2^PT_INDEX_BITS−1 the FSM moves to RUN.
  - bp_ready is 1 only in RUN.
- Lookup is combinational from the arrays:
  - pt_index = lookup_pc[PT_INDEX_BITS+1:2] ^ bhr.
  - The BTB uses index lookup_pc[BTB_INDEX_BITS+1:2] and tag lookup_pc[DBITS-1:BTB_INDEX_BITS+2].
  - btb_hit = valid & tag match.
  - pred_taken = btb_hit & PT[pt_index][1].
  - In INIT: pred_taken=0 and btb_hit=0.
- Update happens at the clock edge when upd_valid is high and the FSM is in RUN. Updates are ignored in INIT.
  - Actual next PC: upd_taken ? upd_target : upd_pc+4.
  - Predicted next PC: upd_pred_taken ? upd_pred_target : upd_pc+4.
  - All additions wrap modulo 2^DBITS.
  - If actual ≠ predicted, the next cycle shows mispredict=1 and redirect_pc = actual.
  - If upd_is_branch=1:
    - PT[upd_pt_index] counts up on taken and down on not-taken, saturating at 0 and 3.
    - If taken, write the BTB entry (valid, tag, upd_target).
    - If upd_is_cond, bhr <= {bhr[PT_INDEX_BITS-2:0], upd_taken}.
  - If upd_is_branch=0 and upd_pred_taken=1 (BTB alias): redirect to upd_pc+4 and invalidate that BTB entry. No PT or BHR change.
- Reset values: bp_ready=0, mispredict=0, redirect_pc=0, bhr=0, stats=0.

## Timing
- Lookup has zero latency.
- Redirect comes exactly 1 cycle after the update cycle.
- Training is visible to lookups from the cycle after the update edge.
- A lookup and an update to the same entry in the same cycle: the lookup sees the old value, with no bypass.
- The sweep takes 2^PT_INDEX_BITS cycles. bp_ready rises on the cycle after the final index write.
- Reset asserted mid-operation: at the next edge the block re-enters INIT at i=0, and bp_ready, mispredict and bhr drop. An update in that cycle is dropped.
- Back-to-back updates are allowed on every cycle.

## Configuration
- GSHARE_BP_STATS_EN defined:
  - stat_branches increments on every accepted update with upd_is_branch=1.
  - stat_mispredicts increments on every cycle in which mispredict is set.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Not defined: both stat outputs are tied to 0 and no counter logic is built.

## Structure
- The shared define header holds:
  - PTINDEXBITS, BTBINDEXBITS, TAGBITS (= DBITS−BTBINDEXBITS−2), PTENTRYBITS (2)
  - INIT/RUN state encodings
  - the update-bus and lookup-bus width macros used to pack FE→DE→AGEX and AGEX→FE.
- One sub-module, bp_btb, holds the tag/valid/target arrays with one combinational read port and one write/invalidate port.
- The PT, BHR, sweep FSM, mispredict logic and statistics live in the top level.

## Test plan
- Reset for 1 cycle, then release → bp_ready=0 for 256 cycles, then 1. During INIT, lookup_pc=0x100 gives pred_taken=0 and btb_hit=0.
- Update pc=0x100, branch, cond, taken, target=0x80, pt_index=0x40, pred_taken=0 → next cycle mispredict=1, redirect_pc=0x80. After that, bhr=0x01, PT[0x40]=2, and lookup 0x100 gives btb_hit=1, pred_target=0x80.
- Four taken updates then one not-taken update to pt_index 0x40 → PT saturates at 3, then reads 2. pred_taken stays 1 for a matching lookup.
- Update pc=0x100, taken, target 0x80, pred_taken=1, pred_target=0x80 → mispredict stays 0.
- Update pc=0x200, non-branch, pred_taken=1 → next cycle mispredict=1, redirect_pc=0x204. The BTB entry for 0x200 is invalidated, PT is unchanged and bhr is unchanged.
- Reset asserted during RUN while an update is presented → the update is dropped, bp_ready=0 next cycle, a full 256-cycle sweep runs again and all lookups miss.
- With GSHARE_BP_STATS_EN, the 2nd and 4th scenarios give stat_branches=2 and stat_mispredicts=1.
